sccb_cfg_seq: RTL

SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

---
 rtl/cam_cfg_pkg.sv | 29 ++
 rtl/sccb_cfg_rom.sv | 59 +++++
 rtl/sccb_cfg_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera SCCB configuration sequencer.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_GAP,
    ST_FINISH
  } cfg_state_e;

  localparam logic [23:0] END_MARK = 24'hFFFFFF;
  localparam logic [15:0] DLY_TAG  = 16'hFFFE;
  localparam logic [7:0]  CAM_SID  = 8'h42;

  // One register write to the camera: {slave ID, reg addr, reg data}.
  function automatic logic [23:0] sccb_wr(input logic [7:0] addr, input logic [7:0] data);
    return {CAM_SID, addr, data};
  endfunction

  // Delay marker: pause for ms milliseconds before the next entry.
  function automatic logic [23:0] dly_ms(input logic [7:0] ms);
    return {DLY_TAG, ms};
  endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Configuration table, synchronous read with one cycle of latency.
// TBL_SEL picks one of the built-in tables (0 = camera bring-up).
module sccb_cfg_rom
  import cam_cfg_pkg::*;
#(
  parameter int unsigned AW      = 6,
  parameter int unsigned TBL_SEL = 0
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [23:0]   data_o
);

  logic [23:0] rd_q;

  function automatic logic [23:0] lookup(input logic [15:0] a);
    logic [23:0] e;
    e = END_MARK;
    case (TBL_SEL)
      1: begin
        case (a)
          16'd0:   e = sccb_wr(8'h12, 8'h80);
          16'd1:   e = sccb_wr(8'h11, 8'h01);
          default: e = END_MARK;
        endcase
      end
      2: begin
        case (a)
          16'd0:   e = sccb_wr(8'h12, 8'h80);
          16'd1:   e = dly_ms(8'd3);
          16'd2:   e = sccb_wr(8'h11, 8'h01);
          default: e = END_MARK;
        endcase
      end
      3: e = sccb_wr(8'h20 + a[7:0], ~a[7:0]);
      default: begin
        case (a)
          16'd0:   e = sccb_wr(8'h12, 8'h80);
          16'd1:   e = dly_ms(8'd10);
          16'd2:   e = sccb_wr(8'h12, 8'h04);
          16'd3:   e = sccb_wr(8'h40, 8'h10);
          16'd4:   e = sccb_wr(8'h8C, 8'h00);
          16'd5:   e = sccb_wr(8'h3A, 8'h04);
          16'd6:   e = sccb_wr(8'h11, 8'h01);
          default: e = END_MARK;
        endcase
      end
    endcase
    return e;
  endfunction

  // Registered table read.
  always_ff @(posedge clk_i) begin
    rd_q <= lookup(16'(addr_i));
  end

  assign data_o = rd_q;

endmodule

// File: rtl/sccb_cfg_seq.sv
// Walks the configuration table after power-up wait, issuing SCCB writes
// and honouring in-table millisecond delay markers.
module sccb_cfg_seq
  import cam_cfg_pkg::*;
#(
  parameter int unsigned CYC_PER_MS  = 25000,
  parameter int unsigned PWR_WAIT_MS = 10,
  parameter int unsigned GAP_CYC     = 64,
  parameter int unsigned TBL_DEPTH   = 64,
  parameter int unsigned TBL_SEL     = 0,
  localparam int unsigned IW = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          I_START,
  output logic [23:0]   O_DATA,
  output logic          O_VALID,
  input  logic          I_READY,
  input  logic          I_DONE,
  output logic          O_BUSY,
  output logic          O_CFG_DONE,
  output logic [IW-1:0] O_IDX
);

  localparam int unsigned CMAX = (CYC_PER_MS > GAP_CYC) ? CYC_PER_MS : GAP_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned MW   = (PWR_WAIT_MS > 255) ? $clog2(PWR_WAIT_MS + 1) : 8;

  localparam logic [IW:0]   IDX_END  = (IW + 1)'(TBL_DEPTH);
  localparam logic [IW:0]   IDX_ONE  = (IW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] MS_LAST  = CW'(CYC_PER_MS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [MW-1:0] MS_ONE   = MW'(1);

  cfg_state_e    state_q, state_d;
  logic [IW:0]   idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] ms_q, ms_d, ms_tgt_q, ms_tgt_d;
  logic          fph_q, fph_d;
  logic [23:0]   data_q, data_d;
  logic          done_q, done_d;
  logic [23:0]   rom_data;
  logic          ms_tick, tmr_done;

  // Index carries one extra bit so reaching TBL_DEPTH is detectable.
  sccb_cfg_rom #(
    .AW      (IW),
    .TBL_SEL (TBL_SEL)
  ) u_rom (
    .clk_i  (I_CLK),
    .addr_i (idx_q[IW-1:0]),
    .data_o (rom_data)
  );

  assign ms_tick  = (cnt_q == MS_LAST);
  assign tmr_done = ms_tick && (ms_q == ms_tgt_q - MS_ONE);

  // State register.
  always_ff @(posedge I_CLK) begin
    if (I_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: index, timers, fetch phase, request data, done flag.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      idx_q    <= '0;
      cnt_q    <= '0;
      ms_q     <= '0;
      ms_tgt_q <= '0;
      fph_q    <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ms_q     <= ms_d;
      ms_tgt_q <= ms_tgt_d;
      fph_q    <= fph_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update. FETCH spans two cycles: the first
  // presents the address, the second decodes the registered table word.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ms_d     = ms_q;
    ms_tgt_d = ms_tgt_q;
    fph_d    = fph_q;
    data_d   = data_q;
    done_d   = done_q;
    case (state_q)
      ST_PWR_WAIT, ST_DELAY: begin
        if (ms_tick) begin
          cnt_d = '0;
          ms_d  = ms_q + MS_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (tmr_done) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          ms_d    = '0;
          fph_d   = 1'b0;
          if (state_q == ST_DELAY) idx_d = idx_q + IDX_ONE;
        end
      end
      ST_FETCH: begin
        if (!fph_q) begin
          if (idx_q == IDX_END) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            fph_d = 1'b1;
          end
        end else begin
          fph_d = 1'b0;
          if (rom_data == END_MARK) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else if (rom_data[23:8] == DLY_TAG) begin
            if (rom_data[7:0] == '0) begin
              idx_d = idx_q + IDX_ONE;
            end else begin
              state_d  = ST_DELAY;
              ms_tgt_d = MW'(rom_data[7:0]);
              cnt_d    = '0;
              ms_d     = '0;
            end
          end else begin
            state_d = ST_ISSUE;
            data_d  = rom_data;
          end
        end
      end
      ST_ISSUE: begin
        if (I_READY) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (I_DONE) begin
          if (GAP_CYC == 0) begin
            state_d = ST_FETCH;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          idx_d   = idx_q + IDX_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default: ;
    endcase
    // Start/restart only where no SCCB transaction can be in flight.
    if (I_START && (state_q inside {ST_IDLE, ST_PWR_WAIT, ST_DELAY, ST_GAP})) begin
      state_d  = (PWR_WAIT_MS == 0) ? ST_FETCH : ST_PWR_WAIT;
      idx_d    = '0;
      cnt_d    = '0;
      ms_d     = '0;
      ms_tgt_d = MW'(PWR_WAIT_MS);
      fph_d    = 1'b0;
      done_d   = 1'b0;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    O_VALID = (state_q == ST_ISSUE);
    O_BUSY  = (state_q != ST_IDLE);
  end

  assign O_DATA     = data_q;
  assign O_CFG_DONE = done_q;
  assign O_IDX      = idx_q[IW-1:0];

endmodule
